pi_cmd_spi_master: RTL and testbench
====================================

// Module: pi_cmd_spi_master
// PURPOSE
// - SPI master that sends one WIDTH-bit lantern/rain command word per request over pisck/pimosi/pien.
// - Exact counterpart of spi_slave_receive_only: that slave samples pimosi on pisck rise, MSB first, and latches the word on pien fall.
// - Used as standalone command source (demo mode, no Pi attached) and as the stimulus driver for receiver-side benches.
// PARAMETERS
// - WIDTH      16  bits per frame; must equal the receiver shift length; >=2
// - CLK_DIV    32  clk cycles per pisck half-period; >=2
// - GAP_CYCLES 64  minimum clk cycles pien stays low between frames; >=1
// PORTS
// - clk        in   1      system clock
// - reset      in   1      asynchronous, active-high
// - cmd_data   in   WIDTH  command word; captured only on the handshake cycle
// - cmd_valid  in   1      request; handshake = cmd_valid && cmd_ready at a clk rise
// - cmd_ready  out  1      high only in IDLE while reset is low
// - busy       out  1      high from the cycle after the handshake until GAP ends
// - done       out  1      one-cycle pulse in the cycle pien falls
// - pisck      out  1      SPI clock, idles low (mode 0)
// - pimosi     out  1      SPI data, MSB first
// - pien       out  1      frame enable, high for the whole frame
// BEHAVIOUR
// - All outputs are registered, so pisck/pien/pimosi are glitch-free. Reset values: pisck=0, pimosi=0, pien=0, done=0, busy=0, cmd_ready=0.
// - FSM states: IDLE -> SHIFT -> TRAIL -> GAP -> IDLE.
// - IDLE: cmd_ready=1. On handshake at cycle t0, load the shift register and the bit counter (WIDTH) and go to SHIFT.
// - SHIFT:
//   - From t0+1: pien=1, pimosi=cmd_data[WIDTH-1], pisck=0.
//   - pisck toggles every CLK_DIV cycles.
//   - Rise k (k=0..WIDTH-1) at t0+1+(2k+1)*CLK_DIV.
//   - Fall k at t0+1+(2k+2)*CLK_DIV. In the same cycle as fall k, pimosi takes bit WIDTH-2-k, so it is stable a full half-period before the next rise.
//   - After fall WIDTH-1: pimosi=0, go to TRAIL.
// - TRAIL: pien stays 1 and pisck stays 0 for CLK_DIV cycles.
//   - pien falls at t0+1+(2*WIDTH+1)*CLK_DIV; done=1 in that cycle.
//   - Defaults: t0+1057.
// - GAP: pien=0 for GAP_CYCLES cycles, then IDLE. cmd_ready rises exactly GAP_CYCLES cycles after pien falls.
// - Exactly WIDTH pisck rises per frame. pisck never rises while pien=0.
// - cmd_valid outside IDLE is ignored; no queueing. Changes to cmd_data after the handshake have no effect on the frame.
// - Dividing counter: $clog2(CLK_DIV) bits; terminal count is CLK_DIV-1, then it wraps to 0.
// - Bit counter: $clog2(WIDTH+1) bits.
// - Reset mid-frame: all outputs go to their reset values immediately (asynchronous). The receiver then latches a partial word on the forced pien fall; software must resend. After reset is released, the FSM is in IDLE and cmd_ready=1 on the first clk rise.
// - A handshake in the same cycle as reset deassertion is not accepted.
// - cmd_data bit map (shared with the decoder):
//   - [15] sunrise, [14] sunset, [13:9] brightness
//   - [8:7] reserved 0, [6:5] speed, [4] rainsnow
//   - [3:2] lightning, [1:0] reserved 0
// STRUCTURE
// - Package lantern_cmd_pkg holds:
//   - CMD_WIDTH=16
//   - field position constants (SUNRISE_BIT, SUNSET_BIT, BRIGHT_HI/LO, SPEED_HI/LO, RAINSNOW_BIT, LIGHT_HI/LO)
//   - typedef enum {IDLE, SHIFT, TRAIL, GAP} spi_tx_state_t
//   - function pack_cmd(sunrise, sunset, bright, speed, rainsnow, lightning), returning a CMD_WIDTH word with reserved bits 0
// - Sub-module sck_tick_gen #(CLK_DIV): enable-gated counter that emits a one-cycle tick every CLK_DIV cycles and restarts on a load pulse.
// - Top level holds the FSM, the shift register, the bit counter and the output registers.
// TESTING
// - Bench receiver model copies spi_slave_receive_only (posedge-pisck shift, negedge-pien latch).
// - Directed scenarios:
//   1. Reset held for 5 cycles, then released -> all outputs 0 during reset; cmd_ready=1 on the first clk after release.
//   2. Defaults, cmd_data=16'hA5C3, 1-cycle valid at t0 -> 16 pisck rises (first at t0+33); pien falls and done pulses at t0+1057; receiver latches 16'hA5C3.
//   3. cmd_valid held high with 16'h0001 then 16'h8000 -> second handshake exactly 64 cycles after the first pien fall; receiver latches 0001 then 8000.
//   4. cmd_data changed to 16'hFFFF one cycle after handshake of 16'h1234 -> receiver latches 16'h1234; busy=1 and cmd_ready=0 for the whole frame.
//   5. Reset asserted after pisck rise 7 of 16'hFFFF -> pisck/pien/pimosi=0 immediately. Next frame 16'h0F0F after release is clean and latches 16'h0F0F.
//   6. CLK_DIV=2, GAP_CYCLES=1, words 16'h0000, 16'hFFFF, pack_cmd(1,0,5'd31,2'b10,1,2'b11)=16'hBE5C -> pien fall at t0+67 each frame; all three words latched exactly.

Source files
------------

// File: rtl/lantern_cmd_pkg.sv
// ---------------------------------------------------------------------------
// lantern_cmd_pkg: command word layout and SPI transmitter state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package lantern_cmd_pkg;

  localparam int CMD_WIDTH    = 16;
  localparam int SUNRISE_BIT  = 15;
  localparam int SUNSET_BIT   = 14;
  localparam int BRIGHT_HI    = 13;
  localparam int BRIGHT_LO    = 9;
  localparam int SPEED_HI     = 6;
  localparam int SPEED_LO     = 5;
  localparam int RAINSNOW_BIT = 4;
  localparam int LIGHT_HI     = 3;
  localparam int LIGHT_LO     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2,
    GAP   = 2'd3
  } spi_tx_state_t;

  // Reserved fields [8:7] and [1:0] are always zero.
  function automatic logic [CMD_WIDTH-1:0] pack_cmd(
    input logic       sunrise,
    input logic       sunset,
    input logic [4:0] bright,
    input logic [1:0] speed,
    input logic       rainsnow,
    input logic [1:0] lightning
  );
    logic [CMD_WIDTH-1:0] w;
    w                     = '0;
    w[SUNRISE_BIT]        = sunrise;
    w[SUNSET_BIT]         = sunset;
    w[BRIGHT_HI:BRIGHT_LO] = bright;
    w[SPEED_HI:SPEED_LO]  = speed;
    w[RAINSNOW_BIT]       = rainsnow;
    w[LIGHT_HI:LIGHT_LO]  = lightning;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sck_tick_gen.sv
// ---------------------------------------------------------------------------
// sck_tick_gen: one-cycle tick every CLK_DIV enabled cycles; load restarts it.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sck_tick_gen #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

`default_nettype wire

// File: rtl/pi_cmd_spi_master.sv
// ---------------------------------------------------------------------------
// pi_cmd_spi_master: mode-0 SPI master sending one command word per request.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pi_cmd_spi_master
  import lantern_cmd_pkg::*;
#(
  parameter int WIDTH      = CMD_WIDTH,
  parameter int CLK_DIV    = 32,
  parameter int GAP_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             busy,
  output logic             done,
  output logic             pisck,
  output logic             pimosi,
  output logic             pien
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  spi_tx_state_t    state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             tick;
  logic             tick_en;
  logic             hs;

  // cmd_ready is registered, so the first cycle after reset can never handshake.
  assign hs      = (state == IDLE) && cmd_ready && cmd_valid;
  assign tick_en = (state == SHIFT) || (state == TRAIL);

  sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .load (hs),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pisck     <= 1'b0;
      pimosi    <= 1'b0;
      pien      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (hs) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            pien      <= 1'b1;
            pisck     <= 1'b0;
            pimosi    <= cmd_data[WIDTH-1];
            sreg      <= {cmd_data[WIDTH-2:0], 1'b0};
            bit_cnt   <= BW'(WIDTH);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!pisck) begin
              pisck <= 1'b1;
            end else begin
              // Data moves on the falling edge: a full half-period of setup.
              pisck   <= 1'b0;
              bit_cnt <= bit_cnt - BW'(1);
              if (bit_cnt == BW'(1)) begin
                pimosi <= 1'b0;
                state  <= TRAIL;
              end else begin
                pimosi <= sreg[WIDTH-1];
                sreg   <= {sreg[WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            pien    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= GW'(GAP_CYCLES - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pi_cmd_spi_master.sv
// ---------------------------------------------------------------------------
// tb_pi_cmd_spi_master: directed bench, default build plus a fast CLK_DIV=2 build.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pi_cmd_spi_master;
  import lantern_cmd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, valid0, valid1;
  logic [15:0] data0, data1;
  logic        ready0, busy0, done0, sck0, mosi0, en0;
  logic        ready1, busy1, done1, sck1, mosi1, en1;

  pi_cmd_spi_master dut_a (
    .clk(clk), .reset(rst0), .cmd_data(data0), .cmd_valid(valid0),
    .cmd_ready(ready0), .busy(busy0), .done(done0),
    .pisck(sck0), .pimosi(mosi0), .pien(en0)
  );

  pi_cmd_spi_master #(.WIDTH(16), .CLK_DIV(2), .GAP_CYCLES(1)) dut_b (
    .clk(clk), .reset(rst1), .cmd_data(data1), .cmd_valid(valid1),
    .cmd_ready(ready1), .busy(busy1), .done(done1),
    .pisck(sck1), .pimosi(mosi1), .pien(en1)
  );

  logic [1:0] ready_v, busy_v, done_v, sck_v, en_v, valid_v;
  assign ready_v = {ready1, ready0};
  assign busy_v  = {busy1, busy0};
  assign done_v  = {done1, done0};
  assign sck_v   = {sck1, sck0};
  assign en_v    = {en1, en0};
  assign valid_v = {valid1, valid0};

  // Receiver models: shift on pisck rise, latch on pien fall.
  logic [15:0] rx_sh0, rx_sh1, rx_w0, rx_w1;
  always @(posedge sck0) rx_sh0 <= {rx_sh0[14:0], mosi0};
  always @(posedge sck1) rx_sh1 <= {rx_sh1[14:0], mosi1};
  always @(negedge en0)  rx_w0  <= rx_sh0;
  always @(negedge en1)  rx_w1  <= rx_sh1;

  int cyc = 0;
  int hs_cnt [2] = '{0, 0};
  int hs_cyc [2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_v[i] && ready_v[i]) begin
        hs_cnt[i]++;
        hs_cyc[i] = cyc;
      end
    end
    cyc++;
  end

  int   rises    [2] = '{0, 0};
  int   rise_cyc [2][256];
  int   falls    [2] = '{0, 0};
  int   fall_cyc [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  int   viol     [2] = '{0, 0};
  int   sck_off  [2] = '{0, 0};
  logic done_at_fall [2];
  logic [1:0] sck_q = 2'b00, en_q = 2'b00;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sck_v[i] && !sck_q[i]) begin
        rise_cyc[i][rises[i] % 256] = cyc;
        if (!en_v[i]) sck_off[i]++;
        rises[i]++;
      end
      if (!en_v[i] && en_q[i]) begin
        fall_cyc[i]     = cyc;
        done_at_fall[i] = done_v[i];
        falls[i]++;
      end
      if (done_v[i]) done_cnt[i]++;
      if ((en_v[i] && !busy_v[i]) || (busy_v[i] && ready_v[i])) viol[i]++;
      sck_q[i] = sck_v[i];
      en_q[i]  = en_v[i];
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int i, input int limit, output int seen);
    seen = -1;
    for (int k = 0; k < limit; k++) begin
      if (ready_v[i]) begin
        seen = cyc;
        break;
      end
      @(negedge clk); #1;
    end
    if (seen < 0) check("ready_timeout", {31'd0, ready_v[i]}, 32'd1);
  endtask

  task automatic wait_fall(input int i, input int n0, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (falls[i] > n0) break;
      @(negedge clk); #1;
    end
    if (falls[i] <= n0) check("fall_timeout", falls[i], n0 + 1);
  endtask

  // Handshake one word; returns t0 = the cycle whose closing edge accepts it.
  task automatic send(input int i, input logic [15:0] w, output int t0);
    int s;
    wait_ready(i, 3000, s);
    if (i == 0) begin valid0 = 1'b1; data0 = w; end
    else        begin valid1 = 1'b1; data1 = w; end
    t0 = cyc;
    @(negedge clk); #1;
    if (i == 0) valid0 = 1'b0; else valid1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, f0, f1, r0, d0, h0, v0, s;
    logic [15:0] w;
    logic [15:0] words [3];

    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = '0; data1 = '0;

    // 1: reset held 5 cycles, then released
    repeat (5) begin
      @(negedge clk); #1;
      check("rst_outs_a", {26'd0, ready0, busy0, done0, sck0, mosi0, en0}, 32'd0);
      check("rst_outs_b", {26'd0, ready1, busy1, done1, sck1, mosi1, en1}, 32'd0);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk); #1;
    check("ready_after_rst_a", {31'd0, ready0}, 32'd1);
    check("ready_after_rst_b", {31'd0, ready1}, 32'd1);
    check("busy_after_rst_a",  {31'd0, busy0},  32'd0);

    // 2: single frame A5C3 with default timing
    r0 = rises[0]; f0 = falls[0]; d0 = done_cnt[0];
    send(0, 16'hA5C3, t0);
    check("first_cycle_outs", {27'd0, busy0, ready0, en0, mosi0, sck0}, 32'b10110);
    wait_fall(0, f0, 2000);
    check("a5c3_fall_cyc", fall_cyc[0], t0 + 1057);
    check("a5c3_first_rise", rise_cyc[0][r0 % 256], t0 + 33);
    check("a5c3_rises", rises[0] - r0, 32'd16);
    check("a5c3_done_at_fall", {31'd0, done_at_fall[0]}, 32'd1);
    check("a5c3_done_count", done_cnt[0] - d0, 32'd1);
    check("a5c3_rx", {16'd0, rx_w0}, 32'h0000A5C3);
    f0 = fall_cyc[0];
    wait_ready(0, 200, s);
    check("a5c3_gap", s, f0 + 64);

    // 3: cmd_valid held through two words
    f0 = falls[0]; h0 = hs_cnt[0];
    valid0 = 1'b1; data0 = 16'h0001;
    @(negedge clk); #1;
    data0 = 16'h8000;
    wait_fall(0, f0, 2000);
    check("held_rx_0001", {16'd0, rx_w0}, 32'h00000001);
    f1 = fall_cyc[0];
    for (int k = 0; k < 200 && hs_cnt[0] < h0 + 2; k++) begin
      @(negedge clk); #1;
    end
    valid0 = 1'b0;
    check("held_hs_count", hs_cnt[0] - h0, 32'd2);
    check("held_second_hs", hs_cyc[0], f1 + 64);
    t1 = hs_cyc[0];
    f0 = falls[0];
    wait_fall(0, f0, 2000);
    check("held_rx_8000", {16'd0, rx_w0}, 32'h00008000);
    check("held_fall_cyc", fall_cyc[0], t1 + 1057);

    // 4: cmd_data changes right after the handshake
    v0 = viol[0]; f0 = falls[0];
    send(0, 16'h1234, t0);
    data0 = 16'hFFFF;
    wait_fall(0, f0, 2000);
    check("late_data_rx", {16'd0, rx_w0}, 32'h00001234);
    wait_ready(0, 200, s);
    check("late_busy_ready_viol", viol[0] - v0, 32'd0);
    check("late_busy_clear", {31'd0, busy0}, 32'd0);

    // 5: reset mid-frame after pisck rise 7, then a clean frame
    r0 = rises[0];
    send(0, 16'hFFFF, t0);
    for (int k = 0; k < 1000 && rises[0] - r0 < 8; k++) begin
      @(negedge clk); #1;
    end
    check("midrst_rises_before", rises[0] - r0, 32'd8);
    rst0 = 1'b1;
    #1;
    check("midrst_spi_outs", {29'd0, sck0, en0, mosi0}, 32'd0);
    check("midrst_ctl_outs", {29'd0, busy0, ready0, done0}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst0 = 1'b0;
    @(negedge clk); #1;
    check("midrst_ready", {31'd0, ready0}, 32'd1);
    r0 = rises[0]; f0 = falls[0];
    send(0, 16'h0F0F, t0);
    wait_fall(0, f0, 2000);
    check("post_rst_rx", {16'd0, rx_w0}, 32'h00000F0F);
    check("post_rst_rises", rises[0] - r0, 32'd16);
    check("post_rst_fall_cyc", fall_cyc[0], t0 + 1057);

    // 6: fast build, CLK_DIV=2 and GAP_CYCLES=1
    w = pack_cmd(1'b1, 1'b0, 5'd31, 2'b10, 1'b1, 2'b11);
    check("pack_cmd", {16'd0, w}, 32'h0000BE5C);
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = w;
    for (int n = 0; n < 3; n++) begin
      r0 = rises[1]; f0 = falls[1];
      send(1, words[n], t0);
      wait_fall(1, f0, 500);
      check("fast_fall_cyc", fall_cyc[1], t0 + 67);
      check("fast_first_rise", rise_cyc[1][r0 % 256], t0 + 3);
      check("fast_rises", rises[1] - r0, 32'd16);
      check("fast_rx", {16'd0, rx_w1}, {16'd0, words[n]});
      f1 = fall_cyc[1];
      wait_ready(1, 50, s);
      check("fast_gap", s, f1 + 1);
    end

    check("sck_while_pien_low_a", sck_off[0], 32'd0);
    check("sck_while_pien_low_b", sck_off[1], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
